rob_ctrl: RTL and testbench

Reorder-buffer controller for the out-of-order backend. It allocates DEPTH reorder entries in program order at rename, marks them complete on execution writeback, and retires them in order through a single commit port. It also handles flush on redirect. The block owns the head/tail pointers and per-entry state, and supplies the rename-freelist and commit logic with lrd/prd/old_prd.

---
 rtl/rob_ctrl.sv | 115 +++++++++++
 tb/tb_rob_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocate, out-of-order complete,
// in-order retire through one commit port, with flush on redirect.
module rob_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [47:0]      enq_pc,
  input  logic [31:0]      enq_instr,
  input  logic [4:0]       enq_lrd,
  input  logic [5:0]       enq_prd,
  input  logic [5:0]       enq_old_prd,
  output logic [IDX_W-1:0] enq_robidx,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_robidx,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [47:0]      commit_pc,
  output logic [31:0]      commit_instr,
  output logic [4:0]       commit_lrd,
  output logic [5:0]       commit_prd,
  output logic [5:0]       commit_old_prd,
  input  logic             flush,
  output logic [IDX_W:0]   count,
  output logic             empty,
  output logic             full
);

  localparam logic [IDX_W:0] PTR_ONE = 1;

  logic [IDX_W:0]   r_head;
  logic [IDX_W:0]   r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_cmpl;
  logic [47:0]      r_pc     [DEPTH];
  logic [31:0]      r_instr  [DEPTH];
  logic [4:0]       r_lrd    [DEPTH];
  logic [5:0]       r_prd    [DEPTH];
  logic [5:0]       r_old    [DEPTH];

  logic [IDX_W-1:0] w_hidx;
  logic [IDX_W-1:0] w_tidx;
  logic             w_full;
  logic             w_enq_fire;
  logic             w_cmt_fire;

  assign w_hidx     = r_head[IDX_W-1:0];
  assign w_tidx     = r_tail[IDX_W-1:0];
  assign w_full     = (w_hidx == w_tidx) &&
                      (r_head[IDX_W] != r_tail[IDX_W]);
  assign enq_ready  = ~w_full & ~flush;
  assign w_enq_fire = enq_valid & enq_ready;
  assign commit_valid = ~flush & r_valid[w_hidx] & r_cmpl[w_hidx];
  assign w_cmt_fire = commit_valid & commit_ready;

  assign enq_robidx     = w_tidx;
  assign count          = r_tail - r_head;
  assign empty          = (r_head == r_tail);
  assign full           = w_full;
  assign commit_pc      = r_pc[w_hidx];
  assign commit_instr   = r_instr[w_hidx];
  assign commit_lrd     = r_lrd[w_hidx];
  assign commit_prd     = r_prd[w_hidx];
  assign commit_old_prd = r_old[w_hidx];

  // Writeback to a free slot is dropped by the valid check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_cmpl  <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_cmpl  <= '0;
    end else begin
      if (wb_valid && r_valid[wb_robidx])
        r_cmpl[wb_robidx] <= 1'b1;
      if (w_cmt_fire) begin
        r_valid[w_hidx] <= 1'b0;
        r_cmpl[w_hidx]  <= 1'b0;
        r_head          <= r_head + PTR_ONE;
      end
      if (w_enq_fire) begin
        r_valid[w_tidx] <= 1'b1;
        r_cmpl[w_tidx]  <= 1'b0;
        r_tail          <= r_tail + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
        r_lrd[i]   <= '0;
        r_prd[i]   <= '0;
        r_old[i]   <= '0;
      end
    end else if (w_enq_fire) begin
      r_pc[w_tidx]    <= enq_pc;
      r_instr[w_tidx] <= enq_instr;
      r_lrd[w_tidx]   <= enq_lrd;
      r_prd[w_tidx]   <= enq_prd;
      r_old[w_tidx]   <= enq_old_prd;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: directed vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_rob_ctrl;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [47:0]      enq_pc = '0;
  logic [31:0]      enq_instr = '0;
  logic [4:0]       enq_lrd = '0;
  logic [5:0]       enq_prd = '0;
  logic [5:0]       enq_old_prd = '0;
  logic [IDX_W-1:0] enq_robidx;
  logic             wb_valid = 1'b0;
  logic [IDX_W-1:0] wb_robidx = '0;
  logic             commit_valid;
  logic             commit_ready = 1'b0;
  logic [47:0]      commit_pc;
  logic [31:0]      commit_instr;
  logic [4:0]       commit_lrd;
  logic [5:0]       commit_prd;
  logic [5:0]       commit_old_prd;
  logic             flush = 1'b0;
  logic [IDX_W:0]   count;
  logic             empty;
  logic             full;

  rob_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_instr(enq_instr), .enq_lrd(enq_lrd),
    .enq_prd(enq_prd), .enq_old_prd(enq_old_prd),
    .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_robidx(wb_robidx),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_lrd(commit_lrd), .commit_prd(commit_prd),
    .commit_old_prd(commit_old_prd),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: program-ordered queue of live entries plus
  // the last data written to each slot.
  typedef struct {
    int         idx;
    bit         c;
  } ent_t;
  ent_t        q[$];
  int          m_head, m_tail;
  logic [47:0] m_pc  [DEPTH];
  logic [31:0] m_ins [DEPTH];
  logic [4:0]  m_lrd [DEPTH];
  logic [5:0]  m_prd [DEPTH];
  logic [5:0]  m_old [DEPTH];

  task automatic model_clear(input bit data);
    q.delete();
    m_head = 0;
    m_tail = 0;
    if (data)
      for (int i = 0; i < DEPTH; i++) begin
        m_pc[i] = '0; m_ins[i] = '0; m_lrd[i] = '0;
        m_prd[i] = '0; m_old[i] = '0;
      end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enq_valid = 0; wb_valid = 0; commit_ready = 0; flush = 0;
    model_clear(1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic step(input bit ev, input bit wv, input int wi,
                      input bit cr, input bit fl);
    int  sz, h;
    bit  x_er, x_cv;
    @(negedge clock);
    enq_valid    = ev;
    enq_pc       = 48'({$urandom(), $urandom()});
    enq_instr    = $urandom();
    enq_lrd      = 5'($urandom());
    enq_prd      = 6'($urandom());
    enq_old_prd  = 6'($urandom());
    wb_valid     = wv;
    wb_robidx    = IDX_W'(wi);
    commit_ready = cr;
    flush        = fl;
    #1;
    sz   = q.size();
    h    = m_head % DEPTH;
    x_er = (sz < DEPTH) && !fl;
    x_cv = !fl && sz > 0 && q[0].c;
    chk("enq_ready", 64'(enq_ready), 64'(x_er));
    chk("enq_robidx", 64'(enq_robidx), 64'(m_tail % DEPTH));
    chk("commit_valid", 64'(commit_valid), 64'(x_cv));
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("commit_pc", 64'(commit_pc), 64'(m_pc[h]));
    chk("commit_instr", 64'(commit_instr), 64'(m_ins[h]));
    chk("commit_lrd", 64'(commit_lrd), 64'(m_lrd[h]));
    chk("commit_prd", 64'(commit_prd), 64'(m_prd[h]));
    chk("commit_old", 64'(commit_old_prd), 64'(m_old[h]));
    @(posedge clock);
    if (fl) begin
      model_clear(0);
    end else begin
      if (wv)
        foreach (q[k]) if (q[k].idx == wi) q[k].c = 1;
      if (x_cv && cr) begin
        void'(q.pop_front());
        m_head++;
      end
      if (ev && x_er) begin
        h = m_tail % DEPTH;
        m_pc[h] = enq_pc; m_ins[h] = enq_instr; m_lrd[h] = enq_lrd;
        m_prd[h] = enq_prd; m_old[h] = enq_old_prd;
        q.push_back('{idx: h, c: 0});
        m_tail++;
      end
    end
  endtask

  typedef struct {
    bit ev; int pc; int prd; int old;
    bit wv; int wi; bit cr;
    int x_idx; int x_cnt; bit x_cv; int x_prd; int x_old; bit x_empty;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 'h1000, 7, 3,  0, 0, 0,  0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0,       0, 0, 0,  1, 1, 0, 7, 3, 0};
    tbl[2]  = '{0, 0, 0, 0,       1, 0, 0,  1, 1, 0, 7, 3, 0};
    tbl[3]  = '{0, 0, 0, 0,       0, 0, 1,  1, 1, 1, 7, 3, 0};
    tbl[4]  = '{0, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 0, 1};
    tbl[5]  = '{1, 'h2000, 10, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1};
    tbl[6]  = '{1, 'h2004, 11, 2, 0, 0, 0,  2, 1, 0, 10, 1, 0};
    tbl[7]  = '{1, 'h2008, 12, 3, 0, 0, 0,  3, 2, 0, 10, 1, 0};
    tbl[8]  = '{0, 0, 0, 0,       1, 3, 0,  4, 3, 0, 10, 1, 0};
    tbl[9]  = '{0, 0, 0, 0,       1, 2, 1,  4, 3, 0, 10, 1, 0};
    tbl[10] = '{0, 0, 0, 0,       1, 1, 1,  4, 3, 0, 10, 1, 0};
    tbl[11] = '{0, 0, 0, 0,       0, 0, 1,  4, 3, 1, 10, 1, 0};
    tbl[12] = '{0, 0, 0, 0,       0, 0, 1,  4, 2, 1, 11, 2, 0};
    tbl[13] = '{0, 0, 0, 0,       0, 0, 1,  4, 1, 1, 12, 3, 0};
    tbl[14] = '{0, 0, 0, 0,       0, 0, 0,  4, 0, 0, 0, 0, 1};

    do_reset();
    #1;
    chk("rst enq_ready", 64'(enq_ready), 64'(1));
    chk("rst robidx", 64'(enq_robidx), 64'(0));
    chk("rst commit_valid", 64'(commit_valid), 64'(0));
    chk("rst commit_pc", 64'(commit_pc), 64'(0));
    chk("rst count", 64'(count), 64'(0));
    chk("rst empty", 64'(empty), 64'(1));
    chk("rst full", 64'(full), 64'(0));

    foreach (tbl[i]) begin
      @(negedge clock);
      enq_valid = tbl[i].ev;
      enq_pc = 48'(tbl[i].pc);
      enq_instr = '0; enq_lrd = '0;
      enq_prd = 6'(tbl[i].prd);
      enq_old_prd = 6'(tbl[i].old);
      wb_valid = tbl[i].wv;
      wb_robidx = IDX_W'(tbl[i].wi);
      commit_ready = tbl[i].cr;
      flush = 0;
      #1;
      chk($sformatf("v%0d robidx", i), 64'(enq_robidx), 64'(tbl[i].x_idx));
      chk($sformatf("v%0d count", i), 64'(count), 64'(tbl[i].x_cnt));
      chk($sformatf("v%0d cvalid", i), 64'(commit_valid), 64'(tbl[i].x_cv));
      chk($sformatf("v%0d cprd", i), 64'(commit_prd), 64'(tbl[i].x_prd));
      chk($sformatf("v%0d cold", i), 64'(commit_old_prd), 64'(tbl[i].x_old));
      chk($sformatf("v%0d empty", i), 64'(empty), 64'(tbl[i].x_empty));
      @(posedge clock);
    end

    // Fill to full, then commit with enqueue held.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, i == 1, 0, 0, 0);
    #1;
    chk("fill full", 64'(full), 64'(1));
    chk("fill count", 64'(count), 64'(DEPTH));
    chk("fill enq_ready", 64'(enq_ready), 64'(0));
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    #1;
    chk("wrap full", 64'(full), 64'(1));
    chk("wrap robidx", 64'(enq_robidx), 64'(1));

    // Simultaneous enq/wb/commit, then writeback to a free slot.
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    #1;
    chk("simul count", 64'(count), 64'(3));
    step(0, 1, 5, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 2, 1, 0);
    step(0, 1, 3, 1, 0);
    step(0, 1, 4, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    #1;
    chk("free wb ignored", 64'(commit_valid), 64'(0));

    // Flush with complete entries at the head.
    do_reset();
    repeat (5) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1);
    #1;
    chk("flush empty", 64'(empty), 64'(1));
    chk("flush count", 64'(count), 64'(0));
    step(1, 0, 0, 0, 0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, i > 0, i - 1, 0, 0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst count", 64'(count), 64'(0));
    chk("arst empty", 64'(empty), 64'(1));
    chk("arst enq_ready", 64'(enq_ready), 64'(1));
    chk("arst robidx", 64'(enq_robidx), 64'(0));
    chk("arst cvalid", 64'(commit_valid), 64'(0));
    chk("arst cprd", 64'(commit_prd), 64'(0));
    model_clear(1);
    enq_valid = 0; wb_valid = 0; commit_ready = 0;
    #1 reset_n = 1'b1;
    step(1, 0, 0, 0, 0);

    // Random traffic with phases biased toward fill and drain.
    for (int n = 0; n < 4000; n++) begin
      int wi;
      bit ev;
      ev = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                : ($urandom_range(0, 3) == 0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        wi = q[$urandom_range(0, q.size() - 1)].idx;
      else
        wi = $urandom_range(0, DEPTH - 1);
      step(ev, $urandom_range(0, 2) != 0, wi,
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
